// File: rtl/stream_credit_pkg.sv
// Shared definitions for the credit-flow stream link (tx and rx credit-return logic).
package stream_credit_pkg;

    // Wide container for credit counts; individual blocks truncate to their own width.
    localparam int CRD_W_MAX = 16;

    typedef logic [CRD_W_MAX-1:0] credit_t;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stream_credit_tx_credit_counter.sv
// Up/down credit counter: loads to Credits on reset/flush, saturates at Credits on an
// unmatched return and raises a sticky overflow flag. Decrement is only ever requested
// while the count is nonzero, so the counter cannot go below zero.
module credit_counter
    import stream_credit_pkg::*;
#(
    parameter int Credits = 8,
    parameter int CW      = credit_width(Credits)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic          i_flush,
    output logic [CW-1:0] o_cnt,
    output logic          o_nz,
    output logic          o_ovf
);

    localparam credit_t       CRD_INIT_W = credit_t'(Credits);
    localparam logic [CW-1:0] CRD_INIT   = CW'(CRD_INIT_W);

    logic [CW-1:0] r_cnt;
    logic          r_ovf;

    // Count update: flush reloads (ignoring returns), simultaneous inc/dec cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CRD_INIT;
            r_ovf <= 1'b0;
        end else if (i_flush) begin
            r_cnt <= CRD_INIT;
        end else begin
            unique case ({i_inc, i_dec})
                2'b10: begin
                    if (r_cnt == CRD_INIT) r_ovf <= 1'b1;
                    else                   r_cnt <= r_cnt + CW'(1);
                end
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_cnt = r_cnt;
    assign o_nz  = (r_cnt != '0);
    assign o_ovf = r_ovf;

endmodule

// File: rtl/stream_credit_tx.sv
// Transmit side of a credit-flow stream link. Forwards accepted beats as registered
// valid-only pulses and tracks remote FIFO space with one credit per free slot.
// Optional: define STREAM_CREDIT_TX_STALL_CNT_EN to add a saturating 32-bit count of
// cycles where the source had a beat but was blocked by lack of credit.
module stream_credit_tx
    import stream_credit_pkg::*;
#(
    parameter  int Credits   = 8,
    parameter  int WordWidth = 64,
    localparam int CW        = credit_width(Credits)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_vld_i,
    input  logic [WordWidth-1:0] src_payload_i,
    output logic                 src_rdy_o,
    output logic                 tx_vld_o,
    output logic [WordWidth-1:0] tx_payload_o,
    input  logic                 crd_rtn_i,
    input  logic                 flush_i,
`ifdef STREAM_CREDIT_TX_STALL_CNT_EN
    output logic [31:0]          stall_cnt_o,
`endif
    output logic [CW-1:0]        credit_o,
    output logic                 err_o
);

    logic                 w_nz;
    logic                 w_fire;
    logic                 r_tx_vld;
    logic [WordWidth-1:0] r_tx_payload;

    assign src_rdy_o = ~rst & ~flush_i & w_nz;
    assign w_fire    = src_vld_i & src_rdy_o;

    credit_counter #(
        .Credits (Credits),
        .CW      (CW)
    ) u_credit_counter (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (crd_rtn_i),
        .i_dec   (w_fire),
        .i_flush (flush_i),
        .o_cnt   (credit_o),
        .o_nz    (w_nz),
        .o_ovf   (err_o)
    );

    // Output beat register: one-cycle valid per fire, payload held between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_vld     <= 1'b0;
            r_tx_payload <= '0;
        end else begin
            r_tx_vld <= w_fire;
            if (w_fire) r_tx_payload <= src_payload_i;
        end
    end

    assign tx_vld_o     = r_tx_vld;
    assign tx_payload_o = r_tx_payload;

`ifdef STREAM_CREDIT_TX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of credit-blocked cycles; flush cycles are not stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (src_vld_i & ~src_rdy_o & ~flush_i & (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
// Directed self-checking bench for stream_credit_tx (Credits=8, WordWidth=64).
module tb_stream_credit_tx;

    localparam int CRED = 8;
    localparam int WW   = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_vld_i;
    logic [WW-1:0] src_payload_i;
    logic          src_rdy_o;
    logic          tx_vld_o;
    logic [WW-1:0] tx_payload_o;
    logic          crd_rtn_i;
    logic          flush_i;
    logic [3:0]    credit_o;
    logic          err_o;
`ifdef STREAM_CREDIT_TX_STALL_CNT_EN
    logic [31:0]   stall_cnt_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stream_credit_tx #(.Credits(CRED), .WordWidth(WW)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_vld_i     (src_vld_i),
        .src_payload_i (src_payload_i),
        .src_rdy_o     (src_rdy_o),
        .tx_vld_o      (tx_vld_o),
        .tx_payload_o  (tx_payload_o),
        .crd_rtn_i     (crd_rtn_i),
        .flush_i       (flush_i),
`ifdef STREAM_CREDIT_TX_STALL_CNT_EN
        .stall_cnt_o   (stall_cnt_o),
`endif
        .credit_o      (credit_o),
        .err_o         (err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; src_vld_i = 1'b0; src_payload_i = '0; crd_rtn_i = 1'b0; flush_i = 1'b0;
        #2;
        n_chk++; if (credit_o !== 4'd8) begin n_fail++; $display("FAIL reset_credit got %0d exp 8", credit_o); end
        n_chk++; if (tx_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_txvld got %0b exp 0", tx_vld_o); end
        n_chk++; if (tx_payload_o !== 64'd0) begin n_fail++; $display("FAIL reset_payload got %0h exp 0", tx_payload_o); end
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", err_o); end
        n_chk++; if (src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %0b exp 0", src_rdy_o); end
        step(); step();
        rst = 1'b0;
        #1;
        n_chk++; if (src_rdy_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_rdy got %0b exp 1", src_rdy_o); end
    endtask

    task automatic test_fill();
        int npulse = 0;
        src_vld_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            src_payload_i = WW'(i);
            step();
            if (tx_vld_o === 1'b1) begin
                npulse++;
                n_chk++;
                if (tx_payload_o !== WW'(npulse)) begin
                    n_fail++; $display("FAIL fill_payload got %0d exp %0d", tx_payload_o, npulse);
                end
            end
        end
        src_vld_i = 1'b0;
        #1;
        n_chk++; if (npulse != 8) begin n_fail++; $display("FAIL fill_pulses got %0d exp 8", npulse); end
        n_chk++; if (credit_o !== 4'd0) begin n_fail++; $display("FAIL fill_credit got %0d exp 0", credit_o); end
        n_chk++; if (src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL fill_rdy got %0b exp 0", src_rdy_o); end
    endtask

    task automatic test_credit_return();
        src_payload_i = 64'd9;
        crd_rtn_i = 1'b1;
        step();
        crd_rtn_i = 1'b0;
        #1;
        n_chk++; if (credit_o !== 4'd1) begin n_fail++; $display("FAIL rtn_credit got %0d exp 1", credit_o); end
        n_chk++; if (src_rdy_o !== 1'b1) begin n_fail++; $display("FAIL rtn_rdy got %0b exp 1", src_rdy_o); end
        src_vld_i = 1'b1;
        step();
        src_vld_i = 1'b0;
        n_chk++; if (tx_vld_o !== 1'b1) begin n_fail++; $display("FAIL rtn_txvld got %0b exp 1", tx_vld_o); end
        n_chk++; if (tx_payload_o !== 64'd9) begin n_fail++; $display("FAIL rtn_payload got %0d exp 9", tx_payload_o); end
        n_chk++; if (credit_o !== 4'd0) begin n_fail++; $display("FAIL rtn_credit_after got %0d exp 0", credit_o); end
        step();
        n_chk++; if (tx_vld_o !== 1'b0) begin n_fail++; $display("FAIL rtn_txvld_drop got %0b exp 0", tx_vld_o); end
        n_chk++; if (tx_payload_o !== 64'd9) begin n_fail++; $display("FAIL rtn_payload_hold got %0d exp 9", tx_payload_o); end
    endtask

    task automatic test_back_to_back();
        crd_rtn_i = 1'b1;
        step(); step(); step();
        n_chk++; if (credit_o !== 4'd3) begin n_fail++; $display("FAIL b2b_setup_credit got %0d exp 3", credit_o); end
        src_vld_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            src_payload_i = WW'(20 + k);
            step();
            n_chk++; if (credit_o !== 4'd3) begin n_fail++; $display("FAIL b2b_credit[%0d] got %0d exp 3", k, credit_o); end
            n_chk++; if (tx_vld_o !== 1'b1 || tx_payload_o !== WW'(20 + k)) begin
                n_fail++; $display("FAIL b2b_beat[%0d] got vld=%0b pl=%0d exp vld=1 pl=%0d", k, tx_vld_o, tx_payload_o, 20 + k);
            end
        end
        src_vld_i = 1'b0; crd_rtn_i = 1'b0;
        step();
        n_chk++; if (tx_vld_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end_txvld got %0b exp 0", tx_vld_o); end
    endtask

    task automatic test_overflow();
        crd_rtn_i = 1'b1;
        for (int k = 0; k < 5; k++) step();
        crd_rtn_i = 1'b0;
        n_chk++; if (credit_o !== 4'd8 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_setup got crd=%0d err=%0b exp crd=8 err=0", credit_o, err_o);
        end
        crd_rtn_i = 1'b1;
        step();
        crd_rtn_i = 1'b0;
        n_chk++; if (credit_o !== 4'd8) begin n_fail++; $display("FAIL ovf_credit got %0d exp 8", credit_o); end
        n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %0b exp 1", err_o); end
        flush_i = 1'b1;
        #1;
        n_chk++; if (src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL ovf_flush_rdy got %0b exp 0", src_rdy_o); end
        step();
        flush_i = 1'b0;
        n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err_after_flush got %0b exp 1", err_o); end
        rst = 1'b1;
        #1;
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL ovf_err_rst got %0b exp 0", err_o); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_flush();
        src_vld_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            src_payload_i = WW'(40 + k);
            step();
        end
        n_chk++; if (credit_o !== 4'd2 || tx_vld_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_setup got crd=%0d vld=%0b exp crd=2 vld=1", credit_o, tx_vld_o);
        end
        flush_i = 1'b1; crd_rtn_i = 1'b1;
        #1;
        n_chk++; if (src_rdy_o !== 1'b0) begin n_fail++; $display("FAIL flush_rdy got %0b exp 0", src_rdy_o); end
        step();
        flush_i = 1'b0; crd_rtn_i = 1'b0; src_vld_i = 1'b0;
        n_chk++; if (credit_o !== 4'd8) begin n_fail++; $display("FAIL flush_credit got %0d exp 8", credit_o); end
        n_chk++; if (tx_vld_o !== 1'b0) begin n_fail++; $display("FAIL flush_txvld got %0b exp 0", tx_vld_o); end
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL flush_err got %0b exp 0", err_o); end
    endtask

    task automatic test_async_reset();
        src_vld_i = 1'b1; src_payload_i = 64'h55;
        step();
        src_vld_i = 1'b0;
        n_chk++; if (tx_vld_o !== 1'b1 || credit_o !== 4'd7) begin
            n_fail++; $display("FAIL arst_setup got vld=%0b crd=%0d exp vld=1 crd=7", tx_vld_o, credit_o);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (tx_vld_o !== 1'b0) begin n_fail++; $display("FAIL arst_txvld got %0b exp 0", tx_vld_o); end
        n_chk++; if (credit_o !== 4'd8) begin n_fail++; $display("FAIL arst_credit got %0d exp 8", credit_o); end
        step();
        rst = 1'b0;
`ifdef STREAM_CREDIT_TX_STALL_CNT_EN
        n_chk++; if (stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL stall_rst got %0d exp 0", stall_cnt_o); end
        src_vld_i = 1'b1;
        for (int k = 0; k < 12; k++) step();
        src_vld_i = 1'b0;
        n_chk++; if (stall_cnt_o !== 32'd4) begin n_fail++; $display("FAIL stall_cnt got %0d exp 4", stall_cnt_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_credit_return();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
